dbc_port_state_machine_multi: RTL and testbench
===============================================

// Module: dbc_port_state_machine_multi
// PURPOSE
//  - N-port xHCI Debug Capability (DbC) port state machine.
//  - Next generation of the single-port DbC port FSM: one independent FSM per port, with
//    sticky status-change bits (CSC/PLC/PRC/CEC) and write-1-to-clear inputs.
//  - Adds an aggregated DbC interrupt (DCI) and an optional enumeration-timeout watchdog.
//  - Sits between the link/enumeration logic (event inputs) and the DbC register file
//    (state, PED, DCR, change bits).
// PARAMETERS
//  - NUM_PORTS     2  number of independent port FSMs (1..8)
//  - ENUM_TIMEOUT  64 cycles allowed in ENABLED before set_config_succesful (>=1)
//  - SW            3  width of one port_state field
// PORTS
//  - clock                 in   1            rising-edge clock; all inputs synchronous to it
//  - reset                 in   1            asynchronous, active-high
//  - DCE                   in   1            DbC enable, global to all ports
//  - connect               in   NUM_PORTS    per-port attach level (1 = attached)
//  - Reset_rcvd            in   NUM_PORTS    per-port bus-reset level from host
//  - set_config_succesful  in   NUM_PORTS    1-cycle pulse: SET_CONFIGURATION accepted
//  - EnumError             in   NUM_PORTS    1-cycle pulse: enumeration failed
//  - Deconfigure           in   NUM_PORTS    1-cycle pulse: configuration 0 set
//  - csc_clr, plc_clr,     in   NUM_PORTS    each: W1C strobe for the matching change bit
//    prc_clr, cec_clr
//  - port_state            out  SW*NUM_PORTS port p state at [SW*p +: SW]
//  - PED                   out  NUM_PORTS    port enabled
//  - DCR                   out  NUM_PORTS    DbC configured (run)
//  - CSC, PLC, PRC, CEC    out  NUM_PORTS    sticky change bits
//  - DCI                   out  1            OR of all change bits, all ports
// BEHAVIOUR
//  - State encoding: OFF=0, DISCONNECTED=1, ENABLED=2, RESETTING=3, CONFIGURED=4, ERROR=5.
//  - Reset: every port_state=OFF; PED, DCR, CSC, PLC, PRC, CEC and DCI all 0.
//  - All outputs are registered. Input sampled at edge k appears at edge k+1.
//    DCI is combinational from the change registers.
//  - Per-port transition priority, highest first:
//    - DCE=0: ->OFF from any state; clears PED, DCR and all change bits.
//    - OFF & DCE=1: ->DISCONNECTED.
//    - Not OFF, not DISCONNECTED, connect=0: ->DISCONNECTED; PED=0, DCR=0, CSC=1.
//    - DISCONNECTED & connect=1: ->ENABLED, CSC=1 (PED stays 0 until the first reset ends).
//    - ENABLED/CONFIGURED/ERROR & Reset_rcvd=1: ->RESETTING; PED=0, DCR=0.
//    - RESETTING & Reset_rcvd=0: ->ENABLED; PED=1, PRC=1, timeout counter loaded.
//    - ENABLED & EnumError: ->ERROR, CEC=1 (EnumError beats set_config_succesful in the same cycle).
//    - ENABLED & set_config_succesful: ->CONFIGURED; DCR=1, PLC=1.
//    - CONFIGURED & Deconfigure: ->ENABLED; DCR=0, PLC=1, timeout counter reloaded.
//    - ERROR: left only via DCE=0, disconnect or Reset_rcvd.
//    - Event pulses arriving in a state that does not accept them are ignored.
//  - Change bits, per port and per bit:
//    - Set and the W1C strobe in the same cycle: set wins.
//    - W1C on a bit that is already 0: no effect.
//  - Ports are fully independent; simultaneous events on different ports are all honoured in the same cycle.
// CONFIGURATION
//  - Macro DBC_ENUM_TIMEOUT_EN:
//    - Defined: per-port down-counter of width $clog2(ENUM_TIMEOUT+1), loaded with ENUM_TIMEOUT on entry to ENABLED.
//      - Decrements each cycle spent in ENABLED.
//      - At 0 with no higher-priority event: ->ERROR, CEC=1, i.e. exactly ENUM_TIMEOUT cycles after entry.
//      - Frozen in all other states.
//    - Undefined: no counter logic; ERROR is reached only via EnumError; ENUM_TIMEOUT is unused.
// TESTING  (NUM_PORTS=2, ENUM_TIMEOUT=8)
//  - Reset mid-run: reset asserted with port0 CONFIGURED -> same cycle port_state=0, DCR=0, DCI=0 asynchronously.
//  - Port0 bring-up: DCE=1, connect=01, Reset_rcvd=01 for 4 cycles then 00, then set_config pulse
//    -> states 1,2,3,2,4; CSC[0]=1, PRC[0]=1, PLC[0]=1, PED[0]=1, DCR[0]=1, port1 stays 1.
//  - W1C race: csc_clr[0] in the same cycle as a disconnect on port0 -> CSC[0] stays 1;
//    next csc_clr[0] -> CSC[0]=0, DCI=0.
//  - Timeout (macro on): port1 enters ENABLED with no set_config -> port_state[5:3]=5 and CEC[1]=1
//    after exactly 8 cycles; macro off -> stays 2 indefinitely.
//  - EnumError and set_config_succesful in the same cycle on port0 in ENABLED -> ERROR, CEC[0]=1, DCR[0]=0.
//  - DCE dropped with both ports CONFIGURED and all change bits set -> both ports OFF,
//    all change bits 0 on the next edge.

Source files
------------

// File: rtl/dbc_port_state_machine_multi.sv
// N-port xHCI DbC port state machine with sticky W1C change bits and an aggregated interrupt.
// Optional enumeration watchdog enabled by defining DBC_ENUM_TIMEOUT_EN.
module dbc_port_state_machine_multi #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned ENUM_TIMEOUT = 64,
  parameter int unsigned SW           = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    DCE,
  input  logic [NUM_PORTS-1:0]    connect,
  input  logic [NUM_PORTS-1:0]    Reset_rcvd,
  input  logic [NUM_PORTS-1:0]    set_config_succesful,
  input  logic [NUM_PORTS-1:0]    EnumError,
  input  logic [NUM_PORTS-1:0]    Deconfigure,
  input  logic [NUM_PORTS-1:0]    csc_clr,
  input  logic [NUM_PORTS-1:0]    plc_clr,
  input  logic [NUM_PORTS-1:0]    prc_clr,
  input  logic [NUM_PORTS-1:0]    cec_clr,
  output logic [SW*NUM_PORTS-1:0] port_state,
  output logic [NUM_PORTS-1:0]    PED,
  output logic [NUM_PORTS-1:0]    DCR,
  output logic [NUM_PORTS-1:0]    CSC,
  output logic [NUM_PORTS-1:0]    PLC,
  output logic [NUM_PORTS-1:0]    PRC,
  output logic [NUM_PORTS-1:0]    CEC,
  output logic                    DCI
);

  localparam logic [2:0] StOff          = 3'd0;
  localparam logic [2:0] StDisconnected = 3'd1;
  localparam logic [2:0] StEnabled      = 3'd2;
  localparam logic [2:0] StResetting    = 3'd3;
  localparam logic [2:0] StConfigured   = 3'd4;
  localparam logic [2:0] StError        = 3'd5;

  if (NUM_PORTS == 0 || NUM_PORTS > 8 || ENUM_TIMEOUT == 0 || SW < 3) begin : g_bad_params
    $error("dbc_port_state_machine_multi: parameter out of range");
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [2:0] state_q, state_d;
    logic       ped_q, ped_d;
    logic       dcr_q, dcr_d;
    logic       csc_q, csc_d, plc_q, plc_d, prc_q, prc_d, cec_q, cec_d;
    logic       csc_set, plc_set, prc_set, cec_set;
    logic       clr_all;
    logic       timeout;

`ifdef DBC_ENUM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(ENUM_TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            load_cnt;

    // Expire on the edge where the count reaches zero: exactly ENUM_TIMEOUT cycles after entry.
    assign timeout  = (state_q == StEnabled) && (cnt_q <= CntW'(1));
    assign load_cnt = (state_d == StEnabled) && (state_q != StEnabled);

    always_comb begin
      cnt_d = cnt_q;
      if (load_cnt) begin
        cnt_d = CntW'(ENUM_TIMEOUT);
      end else if (state_q == StEnabled && cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
      state_d = state_q;
      ped_d   = ped_q;
      dcr_d   = dcr_q;
      csc_set = 1'b0;
      plc_set = 1'b0;
      prc_set = 1'b0;
      cec_set = 1'b0;
      clr_all = 1'b0;
      if (!DCE) begin
        state_d = StOff;
        ped_d   = 1'b0;
        dcr_d   = 1'b0;
        clr_all = 1'b1;
      end else if (state_q == StOff) begin
        state_d = StDisconnected;
      end else if (state_q != StDisconnected && !connect[p]) begin
        state_d = StDisconnected;
        ped_d   = 1'b0;
        dcr_d   = 1'b0;
        csc_set = 1'b1;
      end else begin
        case (state_q)
          StDisconnected: begin
            if (connect[p]) begin
              state_d = StEnabled;
              csc_set = 1'b1;
            end
          end
          StEnabled: begin
            if (Reset_rcvd[p]) begin
              state_d = StResetting;
              ped_d   = 1'b0;
              dcr_d   = 1'b0;
            end else if (EnumError[p]) begin
              state_d = StError;
              cec_set = 1'b1;
            end else if (set_config_succesful[p]) begin
              state_d = StConfigured;
              dcr_d   = 1'b1;
              plc_set = 1'b1;
            end else if (timeout) begin
              state_d = StError;
              cec_set = 1'b1;
            end
          end
          StResetting: begin
            if (!Reset_rcvd[p]) begin
              state_d = StEnabled;
              ped_d   = 1'b1;
              prc_set = 1'b1;
            end
          end
          StConfigured: begin
            if (Reset_rcvd[p]) begin
              state_d = StResetting;
              ped_d   = 1'b0;
              dcr_d   = 1'b0;
            end else if (Deconfigure[p]) begin
              state_d = StEnabled;
              dcr_d   = 1'b0;
              plc_set = 1'b1;
            end
          end
          StError: begin
            if (Reset_rcvd[p]) begin
              state_d = StResetting;
              ped_d   = 1'b0;
              dcr_d   = 1'b0;
            end
          end
          default: begin
            // Illegal encoding: fall back to a safe, unattached state.
            state_d = StDisconnected;
            ped_d   = 1'b0;
            dcr_d   = 1'b0;
          end
        endcase
      end
    end

    // A set in the same cycle as its W1C strobe wins.
    always_comb begin
      csc_d = clr_all ? 1'b0 : (csc_set | (csc_q & ~csc_clr[p]));
      plc_d = clr_all ? 1'b0 : (plc_set | (plc_q & ~plc_clr[p]));
      prc_d = clr_all ? 1'b0 : (prc_set | (prc_q & ~prc_clr[p]));
      cec_d = clr_all ? 1'b0 : (cec_set | (cec_q & ~cec_clr[p]));
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= StOff;
        ped_q   <= 1'b0;
        dcr_q   <= 1'b0;
        csc_q   <= 1'b0;
        plc_q   <= 1'b0;
        prc_q   <= 1'b0;
        cec_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ped_q   <= ped_d;
        dcr_q   <= dcr_d;
        csc_q   <= csc_d;
        plc_q   <= plc_d;
        prc_q   <= prc_d;
        cec_q   <= cec_d;
      end
    end

    assign port_state[SW*p +: SW] = SW'(state_q);
    assign PED[p] = ped_q;
    assign DCR[p] = dcr_q;
    assign CSC[p] = csc_q;
    assign PLC[p] = plc_q;
    assign PRC[p] = prc_q;
    assign CEC[p] = cec_q;
  end

  assign DCI = |(CSC | PLC | PRC | CEC);

endmodule

// File: tb/tb_dbc_port_state_machine_multi.sv
// Directed bench for dbc_port_state_machine_multi (2 ports, 8-cycle enumeration timeout).
module tb_dbc_port_state_machine_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic       DCE;
  logic [1:0] connect, Reset_rcvd, set_config_succesful, EnumError, Deconfigure;
  logic [1:0] csc_clr, plc_clr, prc_clr, cec_clr;
  logic [5:0] port_state;
  logic [1:0] PED, DCR, CSC, PLC, PRC, CEC;
  logic       DCI;

  int checks = 0;
  int errors = 0;
  logic [2:0] p1_after;

  always #5 clock = ~clock;

  dbc_port_state_machine_multi #(
    .NUM_PORTS   (2),
    .ENUM_TIMEOUT(8),
    .SW          (3)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .DCE                 (DCE),
    .connect             (connect),
    .Reset_rcvd          (Reset_rcvd),
    .set_config_succesful(set_config_succesful),
    .EnumError           (EnumError),
    .Deconfigure         (Deconfigure),
    .csc_clr             (csc_clr),
    .plc_clr             (plc_clr),
    .prc_clr             (prc_clr),
    .cec_clr             (cec_clr),
    .port_state          (port_state),
    .PED                 (PED),
    .DCR                 (DCR),
    .CSC                 (CSC),
    .PLC                 (PLC),
    .PRC                 (PRC),
    .CEC                 (CEC),
    .DCI                 (DCI)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; DCE = 1'b0;
    connect = '0; Reset_rcvd = '0; set_config_succesful = '0; EnumError = '0; Deconfigure = '0;
    csc_clr = '0; plc_clr = '0; prc_clr = '0; cec_clr = '0;
    repeat (2) tick();
    chk("rst_state", 32'(port_state), 32'd0);
    chk("rst_ped_dcr", 32'({PED, DCR}), 32'd0);
    chk("rst_chg", 32'({CSC, PLC, PRC, CEC, DCI}), 32'd0);
    reset = 1'b0;

    // Port0 bring-up with a 4-cycle bus reset
    DCE = 1'b1; connect = 2'b01; Reset_rcvd = 2'b01;
    tick(); chk("up_off_to_disc", 32'(port_state), 32'd9);
    tick(); chk("up_enabled", 32'(port_state), 32'd10);
    chk("up_csc", 32'(CSC), 32'd1);
    tick(); chk("up_resetting", 32'(port_state), 32'd11);
    tick(); chk("up_resetting_hold", 32'(port_state), 32'd11);
    chk("up_ped_low", 32'(PED), 32'd0);
    Reset_rcvd = 2'b00;
    tick(); chk("up_reset_done", 32'(port_state), 32'd10);
    chk("up_ped_prc", 32'({PED, PRC}), 32'b01_01);
    set_config_succesful = 2'b01;
    tick(); set_config_succesful = 2'b00;
    chk("up_configured", 32'(port_state), 32'd12);
    chk("up_dcr_plc", 32'({DCR, PLC, DCI}), 32'b01_01_1);

    // Deconfigure with a simultaneous PLC clear: set wins
    Deconfigure = 2'b01; plc_clr = 2'b01;
    tick(); Deconfigure = 2'b00; plc_clr = 2'b00;
    chk("deconf_state", 32'(port_state), 32'd10);
    chk("deconf_dcr_plc", 32'({DCR, PLC}), 32'b00_01);
    set_config_succesful = 2'b01;
    tick(); set_config_succesful = 2'b00;
    chk("reconf_state", 32'(port_state), 32'd12);

    // Asynchronous reset mid-run
    reset = 1'b1;
    #1;
    chk("async_state", 32'(port_state), 32'd0);
    chk("async_dcr_dci", 32'({DCR, DCI}), 32'd0);
    tick();
    reset = 1'b0;
    tick(); chk("rerun_disc", 32'(port_state), 32'd9);
    tick(); chk("rerun_enabled", 32'(port_state), 32'd10);

    // EnumError beats set_config in the same cycle
    EnumError = 2'b01; set_config_succesful = 2'b01;
    tick(); EnumError = 2'b00; set_config_succesful = 2'b00;
    chk("enumerr_state", 32'(port_state), 32'd13);
    chk("enumerr_cec_dcr", 32'({CEC, DCR}), 32'b01_00);

    // W1C race against a disconnect
    connect = 2'b00; csc_clr = 2'b01; cec_clr = 2'b01;
    tick(); csc_clr = 2'b00; cec_clr = 2'b00;
    chk("race_state", 32'(port_state), 32'd9);
    chk("race_csc_kept", 32'({CSC, CEC, DCI}), 32'b01_00_1);
    csc_clr = 2'b01; cec_clr = 2'b01;
    tick(); csc_clr = 2'b00; cec_clr = 2'b00;
    chk("race_cleared", 32'({CSC, CEC, DCI}), 32'd0);

    // Port1 sits in ENABLED without configuration
    connect = 2'b10;
    tick(); chk("to_p1_enabled", 32'(port_state), 32'd17);
    for (int i = 1; i < 8; i++) begin
      tick(); chk("to_wait", 32'(port_state[5:3]), 32'd2);
    end
`ifdef DBC_ENUM_TIMEOUT_EN
    p1_after = 3'd5;
`else
    p1_after = 3'd2;
`endif
    tick();
    chk("to_expiry_state", 32'(port_state[5:3]), 32'(p1_after));
    chk("to_expiry_cec", 32'(CEC[1]), 32'(p1_after == 3'd5));
    repeat (12) tick();
    chk("to_later_state", 32'(port_state), 32'({p1_after, 3'd1}));

    // Drive both ports to CONFIGURED with every change bit set
    connect = 2'b11; EnumError = 2'b10;
    tick(); chk("both_a", 32'(port_state), 32'd42);
    EnumError = 2'b01;
    tick(); EnumError = 2'b00;
    chk("both_b", 32'(port_state), 32'd45);
    Reset_rcvd = 2'b11;
    tick(); chk("both_c", 32'(port_state), 32'd27);
    chk("both_c_ped", 32'(PED), 32'd0);
    Reset_rcvd = 2'b00;
    tick(); chk("both_d", 32'(port_state), 32'd18);
    chk("both_d_ped", 32'(PED), 32'd3);
    set_config_succesful = 2'b11;
    tick(); set_config_succesful = 2'b00;
    chk("both_cfg", 32'(port_state), 32'd36);
    chk("both_bits", 32'({DCR, CSC, PLC, PRC, CEC, DCI}), 32'b11_11_11_11_11_1);

    // DCE drop: both ports OFF and everything cleared on the next edge
    DCE = 1'b0;
    tick();
    chk("dce_state", 32'(port_state), 32'd0);
    chk("dce_bits", 32'({PED, DCR, CSC, PLC, PRC, CEC, DCI}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
